gate_truth_checker: RTL and testbench

GATE_TRUTH_CHECKER -- requirements
Module: gate_truth_checker

---
 rtl/gate_truth_checker.sv | 142 ++++++++++++++
 tb/tb_gate_truth_checker.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gate_truth_checker.sv
// Drives all four {a,b} vectors into a 2-input gate, captures its response per vector
// and compares against EXPECT. Optional saturating error counter under GATE_CHECKER_ERRCNT_EN.
module gate_truth_checker #(
    parameter logic [3:0]  EXPECT        = 4'b0111,
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       a_o,
    output logic       b_o,
    input  logic       out_i,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] result,
    output logic [3:0] fail_mask
`ifdef GATE_CHECKER_ERRCNT_EN
    ,
    output logic [7:0] err_count
`endif
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [7:0] SETTLE = 8'(SETTLE_CYCLES);

    state_t     state_q, state_d;
    logic [1:0] idx_q, idx_d;
    logic [7:0] cnt_q, cnt_d;
    logic       done_q, done_d;
    logic       pass_q, pass_d;
    logic [3:0] result_q, result_d;
    logic [3:0] fail_q, fail_d;
    logic [3:0] fail_new;
    logic       sample;
    logic       last_sample;

    // The vector index doubles as the registered stimulus: {a_o,b_o} == idx_q.
    always_comb begin
        sample      = (state_q == RUN) && (cnt_q == 8'd1);
        last_sample = sample && (idx_q == 2'd3);
        fail_new         = fail_q;
        fail_new[idx_q]  = out_i ^ EXPECT[idx_q];
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        pass_d   = pass_q;
        result_d = result_q;
        fail_d   = fail_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = RUN;
                    idx_d    = 2'd0;
                    cnt_d    = SETTLE;
                    result_d = 4'b0000;
                    fail_d   = 4'b0000;
                    pass_d   = 1'b0;
                end
            end
            RUN: begin
                cnt_d = cnt_q - 8'd1;
                if (sample) begin
                    result_d[idx_q] = out_i;
                    fail_d          = fail_new;
                    if (last_sample) begin
                        state_d = IDLE;
                        idx_d   = 2'd0;
                        done_d  = 1'b1;
                        pass_d  = (fail_new == 4'b0000);
                    end else begin
                        idx_d = idx_q + 2'd1;
                        cnt_d = SETTLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= 2'd0;
            cnt_q    <= 8'd0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            result_q <= 4'b0000;
            fail_q   <= 4'b0000;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
            result_q <= result_d;
            fail_q   <= fail_d;
        end
    end

    assign a_o       = idx_q[1];
    assign b_o       = idx_q[0];
    assign busy      = (state_q == RUN);
    assign done      = done_q;
    assign pass      = pass_q;
    assign result    = result_q;
    assign fail_mask = fail_q;

`ifdef GATE_CHECKER_ERRCNT_EN
    logic [7:0] err_q, err_d;
    logic [8:0] err_sum;

    // Counts mismatching vectors across runs; only reset clears it.
    always_comb begin
        err_sum = {1'b0, err_q} + 9'(fail_new[0]) + 9'(fail_new[1])
                + 9'(fail_new[2]) + 9'(fail_new[3]);
        err_d   = err_q;
        if (last_sample) begin
            err_d = (err_sum > 9'd255) ? 8'd255 : err_sum[7:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 8'd0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_count = err_q;
`endif

endmodule

// File: tb/tb_gate_truth_checker.sv
// Bench for gate_truth_checker: two instances (SETTLE 1 and 3) checked each cycle
// against a timeline model, plus literal expectations for the canonical runs.
module tb_gate_truth_checker;

    localparam logic [3:0] EXP = 4'b0111;
    localparam int S0 = 1;
    localparam int S1 = 3;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       start_v [2] = '{1'b0, 1'b0};
    logic [3:0] tbl_v   [2] = '{4'b0111, 4'b0111};
    logic       a_v [2], b_v [2], out_v [2], busy_v [2], done_v [2], pass_v [2];
    logic [3:0] res_v [2], fm_v [2];
`ifdef GATE_CHECKER_ERRCNT_EN
    logic [7:0] err_v [2];
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Gate under test: a lookup of the current table at index {a,b}.
    assign out_v[0] = tbl_v[0][{a_v[0], b_v[0]}];
    assign out_v[1] = tbl_v[1][{a_v[1], b_v[1]}];

    gate_truth_checker #(.EXPECT(EXP), .SETTLE_CYCLES(S0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .a_o(a_v[0]), .b_o(b_v[0]),
        .out_i(out_v[0]), .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]),
        .result(res_v[0]), .fail_mask(fm_v[0])
`ifdef GATE_CHECKER_ERRCNT_EN
        , .err_count(err_v[0])
`endif
    );

    gate_truth_checker #(.EXPECT(EXP), .SETTLE_CYCLES(S1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .a_o(a_v[1]), .b_o(b_v[1]),
        .out_i(out_v[1]), .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]),
        .result(res_v[1]), .fail_mask(fm_v[1])
`ifdef GATE_CHECKER_ERRCNT_EN
        , .err_count(err_v[1])
`endif
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sett(input int k);
        return (k == 0) ? S0 : S1;
    endfunction

    // Model: a run is a timeline of 4*S cycles after the accepting edge; vector = elapsed/S.
    bit       m_run  [2];
    int       m_c    [2];
    bit       m_done [2];
    bit       m_pass [2];
    bit [3:0] m_res  [2];
    bit [3:0] m_fail [2];
    bit [3:0] m_tbl  [2];
    int       m_err  [2];

    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                m_run[k] = 0; m_c[k] = 0; m_done[k] = 0; m_pass[k] = 0;
                m_res[k] = 0; m_fail[k] = 0; m_err[k] = 0;
            end else begin
                m_done[k] = 0;
                if (m_run[k]) begin
                    m_c[k]++;
                    if (m_c[k] == 4 * sett(k)) begin
                        m_run[k]  = 0;
                        m_done[k] = 1;
                        m_res[k]  = m_tbl[k];
                        m_fail[k] = m_tbl[k] ^ EXP;
                        m_pass[k] = (m_fail[k] == 0);
                        m_err[k]  = m_err[k] + $countones(m_fail[k]);
                        if (m_err[k] > 255) m_err[k] = 255;
                    end
                end else if (start_v[k]) begin
                    m_run[k]  = 1;
                    m_c[k]    = 0;
                    m_tbl[k]  = tbl_v[k];
                    m_res[k]  = 0;
                    m_fail[k] = 0;
                    m_pass[k] = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            int       vec;
            bit [3:0] e_res, e_fail;
            vec    = m_run[k] ? (m_c[k] / sett(k)) : 0;
            e_res  = m_res[k];
            e_fail = m_fail[k];
            if (m_run[k]) begin
                e_res  = 0;
                e_fail = 0;
                for (int v = 0; v < 4; v++) begin
                    if ((v + 1) * sett(k) <= m_c[k]) begin
                        e_res[v]  = m_tbl[k][v];
                        e_fail[v] = m_tbl[k][v] ^ EXP[v];
                    end
                end
            end
            chk($sformatf("d%0d_busy", k), 64'(busy_v[k]), 64'(m_run[k]));
            chk($sformatf("d%0d_done", k), 64'(done_v[k]), 64'(m_done[k]));
            chk($sformatf("d%0d_ab", k), 64'({a_v[k], b_v[k]}), 64'(vec[1:0]));
            chk($sformatf("d%0d_result", k), 64'(res_v[k]), 64'(e_res));
            chk($sformatf("d%0d_fail_mask", k), 64'(fm_v[k]), 64'(e_fail));
            chk($sformatf("d%0d_pass", k), 64'(pass_v[k]), 64'(m_run[k] ? 1'b0 : m_pass[k]));
`ifdef GATE_CHECKER_ERRCNT_EN
            chk($sformatf("d%0d_err_count", k), 64'(err_v[k]), 64'(m_err[k]));
`endif
        end
    end

    // Launch a run on instance k and return edges from the accepting edge to done.
    task automatic run(input int k, input logic [3:0] tbl, input int restart_at,
                       input bit chain, output int lat);
        int          n;
        logic [63:0] seq_act, seq_exp;
        n       = 0;
        seq_act = 0;
        seq_exp = 0;
        tbl_v[k]   = tbl;
        start_v[k] = 1'b1;
        forever begin
            @(negedge clk);
            n++;
            seq_act = {seq_act[61:0], a_v[k], b_v[k]};
            if (n == 1) begin
                chk($sformatf("d%0d_first_cycle", k),
                    64'({busy_v[k], pass_v[k], res_v[k], fm_v[k]}), 64'({1'b1, 1'b0, 8'h00}));
            end
            if (done_v[k]) begin
                start_v[k] = chain;
                break;
            end
            start_v[k] = (n == restart_at);
            if (n > 200) begin
                chk($sformatf("d%0d_done_timeout", k), 64'(0), 64'(1));
                start_v[k] = 1'b0;
                break;
            end
        end
        lat = n - 1;
        for (int v = 0; v < 4; v++) begin
            for (int r = 0; r < sett(k); r++) seq_exp = {seq_exp[61:0], 2'(v)};
        end
        seq_exp = {seq_exp[61:0], 2'b00};
        chk($sformatf("d%0d_ab_sequence", k), seq_act, seq_exp);
    endtask

    initial begin
        int       lat;
        int       k;
        bit       ch;
        logic [3:0] t;

        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", 64'({busy_v[0], done_v[0], pass_v[0], a_v[0], b_v[0], res_v[0], fm_v[0]}), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);

        run(0, 4'b0111, 0, 0, lat);
        chk("nand_latency", 64'(lat), 64'(4));
        chk("nand_result", 64'(res_v[0]), 64'(4'b0111));
        chk("nand_fail_mask", 64'(fm_v[0]), 64'(4'b0000));
        chk("nand_pass", 64'(pass_v[0]), 64'(1));

        run(0, 4'b1111, 0, 0, lat);
        chk("stuck1_result", 64'({res_v[0], fm_v[0], pass_v[0]}), 64'({4'b1111, 4'b1000, 1'b0}));

        repeat (2) begin
            run(0, 4'b1000, 0, 0, lat);
            chk("and_result", 64'({res_v[0], fm_v[0], pass_v[0]}), 64'({4'b1000, 4'b1111, 1'b0}));
        end
`ifdef GATE_CHECKER_ERRCNT_EN
        chk("err_count_after_three", 64'(err_v[0]), 64'(9));
`endif

        run(1, 4'b0111, 0, 0, lat);
        chk("settle3_latency", 64'(lat), 64'(12));
        chk("settle3_pass", 64'({res_v[1], pass_v[1]}), 64'({4'b0111, 1'b1}));

        run(0, 4'b0111, 2, 0, lat);
        chk("restart_ignored_latency", 64'(lat), 64'(4));

        run(0, 4'b0111, 0, 1, lat);
        run(0, 4'b1000, 0, 0, lat);
        chk("chained_latency", 64'(lat), 64'(4));
        chk("chained_result", 64'(res_v[0]), 64'(4'b1000));

        // Reset in the middle of a run, asserted while the clock is low.
        tbl_v[0]   = 4'b0111;
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1 chk("midrun_reset_outputs",
               64'({busy_v[0], done_v[0], pass_v[0], a_v[0], b_v[0], res_v[0], fm_v[0]}), 64'(0));
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run(0, 4'b0111, 0, 0, lat);
        chk("post_reset_run", 64'({lat[7:0], res_v[0], pass_v[0]}), 64'({8'd4, 4'b0111, 1'b1}));

        for (int i = 0; i < 24; i++) begin
            k  = $urandom_range(0, 1);
            t  = 4'($urandom_range(0, 15));
            ch = 1'($urandom_range(0, 1));
            if (i == 23) ch = 0;
            run(k, t, $urandom_range(0, 3), ch, lat);
            chk("rand_latency", 64'(lat), 64'(4 * sett(k)));
            chk("rand_result", 64'({res_v[k], fm_v[k], pass_v[k]}), 64'({t, t ^ EXP, t == EXP}));
            if (!ch) repeat ($urandom_range(0, 2)) @(negedge clk);
            else begin
                run(k, t, 0, 0, lat);
                chk("rand_chained_result", 64'({lat[7:0], res_v[k]}), 64'({8'(4 * sett(k)), t}));
            end
        end

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
